tmp101_temperature_formatter: RTL and testbench

TMP101_TEMPERATURE_FORMATTER -- requirements
Module: tmp101_temperature_formatter

---
 rtl/tmp101_temperature_formatter_if.sv | 28 ++
 rtl/tmp101_temperature_formatter.sv | 165 ++++++++++++++++
 tb/tb_tmp101_temperature_formatter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tmp101_temperature_formatter_if.sv
// Byte-stream in / formatted temperature out bundle for the TMP101 formatter.
// master drives the received bytes and Clear; slave is the formatter itself.
interface tmp101_temperature_formatter_if #(
    parameter int FRAC_BITS = 4
) ();
    logic                   ByteValid;
    logic [7:0]             ReceivedData;
    logic                   Clear;
    logic [8+FRAC_BITS-1:0] TempRaw;
    logic                   SignOut;
    logic [3:0]             Hundreds;
    logic [3:0]             Tens;
    logic [3:0]             Ones;
    logic [3:0]             Tenths;
    logic                   DataValid;
    logic                   Busy;
    logic                   Overrun;

    modport master (
        output ByteValid, ReceivedData, Clear,
        input  TempRaw, SignOut, Hundreds, Tens, Ones, Tenths, DataValid, Busy, Overrun
    );

    modport slave (
        input  ByteValid, ReceivedData, Clear,
        output TempRaw, SignOut, Hundreds, Tens, Ones, Tenths, DataValid, Busy, Overrun
    );
endinterface

// File: rtl/tmp101_temperature_formatter.sv
// Pairs TMP101 MSB/LSB bytes into a raw reading and converts its magnitude to
// sign + BCD hundreds/tens/ones/tenths with a fixed 9-edge conversion latency.
module tmp101_temperature_formatter #(
    parameter int FRAC_BITS = 4
) (
    input logic                          clock,
    input logic                          Reset,
    tmp101_temperature_formatter_if.slave bus
);
    localparam int RAW_W  = 8 + FRAC_BITS;
    localparam int PROD_W = 4 + FRAC_BITS;

    typedef enum logic [1:0] {WAIT_MSB, WAIT_LSB, CONVERT, DONE} state_e;

    state_e             state_q, state_d;
    logic [7:0]         msb_q, msb_d;
    logic [RAW_W-1:0]   raw_q, raw_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               dabble_done_q, dabble_done_d;
    logic [RAW_W-1:0]   mag_sh_q, mag_sh_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [RAW_W-1:0]   temp_raw_q, temp_raw_d;
    logic               sign_q, sign_d;
    logic [3:0]         hundreds_q, hundreds_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic [3:0]         tenths_q, tenths_d;
    logic               overrun_q, overrun_d;

    logic               busy;
    logic [RAW_W-1:0]   new_raw;
    logic [RAW_W-1:0]   new_mag;
    logic [FRAC_BITS-1:0] frac_mag;
    logic [PROD_W-1:0]  tenths_prod;
    logic [11:0]        bcd_adj;
    logic               bcd_overflow_unused;
    logic               unused_lsb_bits;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    assign busy            = (state_q == CONVERT) || (state_q == DONE);
    assign unused_lsb_bits = ^bus.ReceivedData[7-FRAC_BITS:0];

    assign new_raw = {msb_q, bus.ReceivedData[7 -: FRAC_BITS]};
    assign new_mag = new_raw[RAW_W-1] ? (~new_raw + RAW_W'(1)) : new_raw;
    // The low bits of a full negation equal the negation of the low bits alone.
    assign frac_mag    = raw_q[RAW_W-1] ? (FRAC_BITS'(0) - raw_q[FRAC_BITS-1:0])
                                        : raw_q[FRAC_BITS-1:0];
    assign tenths_prod = PROD_W'(frac_mag) * PROD_W'(10);
    assign bcd_adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d             = state_q;
        msb_d               = msb_q;
        raw_d               = raw_q;
        cnt_d               = cnt_q;
        dabble_done_d       = dabble_done_q;
        mag_sh_d            = mag_sh_q;
        bcd_d               = bcd_q;
        temp_raw_d          = temp_raw_q;
        sign_d              = sign_q;
        hundreds_d          = hundreds_q;
        tens_d              = tens_q;
        ones_d              = ones_q;
        tenths_d            = tenths_q;
        overrun_d           = overrun_q;
        bcd_overflow_unused = 1'b0;

        if (bus.Clear) begin
            state_d       = WAIT_MSB;
            cnt_d         = '0;
            dabble_done_d = 1'b0;
            overrun_d     = 1'b0;
        end else begin
            if (busy && bus.ByteValid) overrun_d = 1'b1;

            unique case (state_q)
                WAIT_MSB: begin
                    if (bus.ByteValid) begin
                        msb_d   = bus.ReceivedData;
                        state_d = WAIT_LSB;
                    end
                end
                WAIT_LSB: begin
                    if (bus.ByteValid) begin
                        raw_d         = new_raw;
                        mag_sh_d      = new_mag;
                        bcd_d         = '0;
                        cnt_d         = '0;
                        dabble_done_d = 1'b0;
                        state_d       = CONVERT;
                    end
                end
                CONVERT: begin
                    if (!dabble_done_q) begin
                        // The integer part sits at the top of the magnitude; shift it out MSB first.
                        {bcd_overflow_unused, bcd_d} = {bcd_adj, mag_sh_q[RAW_W-1]};
                        mag_sh_d = {mag_sh_q[RAW_W-2:0], 1'b0};
                        cnt_d    = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) dabble_done_d = 1'b1;
                    end else begin
                        temp_raw_d    = raw_q;
                        sign_d        = raw_q[RAW_W-1];
                        hundreds_d    = bcd_q[11:8];
                        tens_d        = bcd_q[7:4];
                        ones_d        = bcd_q[3:0];
                        tenths_d      = 4'(tenths_prod >> FRAC_BITS);
                        dabble_done_d = 1'b0;
                        state_d       = DONE;
                    end
                end
                DONE:    state_d = WAIT_MSB;
                default: state_d = WAIT_MSB;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= WAIT_MSB;
            msb_q         <= '0;
            raw_q         <= '0;
            cnt_q         <= '0;
            dabble_done_q <= 1'b0;
            mag_sh_q      <= '0;
            bcd_q         <= '0;
            temp_raw_q    <= '0;
            sign_q        <= 1'b0;
            hundreds_q    <= '0;
            tens_q        <= '0;
            ones_q        <= '0;
            tenths_q      <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            msb_q         <= msb_d;
            raw_q         <= raw_d;
            cnt_q         <= cnt_d;
            dabble_done_q <= dabble_done_d;
            mag_sh_q      <= mag_sh_d;
            bcd_q         <= bcd_d;
            temp_raw_q    <= temp_raw_d;
            sign_q        <= sign_d;
            hundreds_q    <= hundreds_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            tenths_q      <= tenths_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.TempRaw   = temp_raw_q;
    assign bus.SignOut   = sign_q;
    assign bus.Hundreds  = hundreds_q;
    assign bus.Tens      = tens_q;
    assign bus.Ones      = ones_q;
    assign bus.Tenths    = tenths_q;
    assign bus.DataValid = (state_q == DONE);
    assign bus.Busy      = busy;
    assign bus.Overrun   = overrun_q;
endmodule

// File: tb/tb_tmp101_temperature_formatter.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// and compares them whenever DataValid is seen, including the cycle it arrives.
module tb_tmp101_temperature_formatter;
    typedef struct {
        logic [11:0] raw;
        logic        sign;
        logic [3:0]  h, t, o, f;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  m, l;
        logic [11:0] raw;
        logic        sign;
        logic [3:0]  h, t, o, f;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_edge = 0;
    logic        clock = 1'b0;
    logic        Reset = 1'b0;

    tmp101_temperature_formatter_if #(.FRAC_BITS(4)) bus ();

    tmp101_temperature_formatter #(.FRAC_BITS(4)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    vec_t vecs[10] = '{
        '{8'h19, 8'h00, 12'h190, 1'b0, 4'd0, 4'd2, 4'd5, 4'd0},
        '{8'h7F, 8'hF0, 12'h7FF, 1'b0, 4'd1, 4'd2, 4'd7, 4'd9},
        '{8'h00, 8'h80, 12'h008, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5},
        '{8'hE7, 8'h00, 12'hE70, 1'b1, 4'd0, 4'd2, 4'd5, 4'd0},
        '{8'hFF, 8'hF0, 12'hFFF, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0},
        '{8'h80, 8'h00, 12'h800, 1'b1, 4'd1, 4'd2, 4'd8, 4'd0},
        '{8'h4B, 8'h5F, 12'h4B5, 1'b0, 4'd0, 4'd7, 4'd5, 4'd3},
        '{8'hF6, 8'h80, 12'hF68, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5},
        '{8'h63, 8'hE0, 12'h63E, 1'b0, 4'd0, 4'd9, 4'd9, 4'd8},
        '{8'h64, 8'h00, 12'h640, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (Reset && bus.DataValid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_datavalid: DataValid at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("latency",  32'(cyc),          32'(mon_e.cyc));
                check("temp_raw", 32'(bus.TempRaw),  32'(mon_e.raw));
                check("sign",     32'(bus.SignOut),  32'(mon_e.sign));
                check("hundreds", 32'(bus.Hundreds), 32'(mon_e.h));
                check("tens",     32'(bus.Tens),     32'(mon_e.t));
                check("ones",     32'(bus.Ones),     32'(mon_e.o));
                check("tenths",   32'(bus.Tenths),   32'(mon_e.f));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(posedge clock); #1;
        bus.ByteValid    = 1'b1;
        bus.ReceivedData = b;
        bus.Clear        = clr;
        @(posedge clock); #1;
        last_edge        = cyc;
        bus.ByteValid    = 1'b0;
        bus.Clear        = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clock); #1;
        bus.Clear = 1'b1;
        @(posedge clock); #1;
        bus.Clear = 1'b0;
    endtask

    task automatic send_pair(input vec_t v);
        exp_t e;
        send_byte(v.m, 1'b0);
        send_byte(v.l, 1'b0);
        e.raw  = v.raw;
        e.sign = v.sign;
        e.h    = v.h;
        e.t    = v.t;
        e.o    = v.o;
        e.f    = v.f;
        e.cyc  = last_edge + 9;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [11:0] raw, input logic sign,
                                 input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                 input logic [3:0] f);
        check({tag, "_raw"},      32'(bus.TempRaw),  32'(raw));
        check({tag, "_sign"},     32'(bus.SignOut),  32'(sign));
        check({tag, "_hundreds"}, 32'(bus.Hundreds), 32'(h));
        check({tag, "_tens"},     32'(bus.Tens),     32'(t));
        check({tag, "_ones"},     32'(bus.Ones),     32'(o));
        check({tag, "_tenths"},   32'(bus.Tenths),   32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ByteValid    = 1'b0;
        bus.ReceivedData = 8'h00;
        bus.Clear        = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset", 12'h000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("reset_datavalid", 32'(bus.DataValid), 32'd0);
        check("reset_busy",      32'(bus.Busy),      32'd0);
        check("reset_overrun",   32'(bus.Overrun),   32'd0);
        Reset = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 10; i++) begin
            send_pair(vecs[i]);
            wait_drain();
        end
        check_outputs("hold", 12'h640, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0);

        // Stray byte three edges after the LSB: ignored, sticky Overrun.
        send_pair(vecs[0]);
        @(posedge clock); #1;
        check("busy_in_convert", 32'(bus.Busy), 32'd1);
        send_byte(8'h55, 1'b0);
        check("overrun_set", 32'(bus.Overrun), 32'd1);
        wait_drain();
        check("overrun_sticky", 32'(bus.Overrun), 32'd1);
        pulse_clear();
        check("overrun_cleared", 32'(bus.Overrun), 32'd0);

        // Clear after a lone MSB discards it.
        send_byte(8'h19, 1'b0);
        pulse_clear();
        send_pair('{8'h32, 8'h00, 12'h320, 1'b0, 4'd0, 4'd5, 4'd0, 4'd0});
        wait_drain();

        // Clear with ByteValid while idle drops the byte.
        send_byte(8'h19, 1'b1);
        send_pair('{8'h0A, 8'h00, 12'h0A0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0});
        wait_drain();

        // Clear with ByteValid mid-conversion: abandoned, no Overrun, results held.
        send_byte(8'h21, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b1);
        check("clear_bv_overrun", 32'(bus.Overrun), 32'd0);
        repeat (15) @(posedge clock);
        #1;
        check_outputs("clear_hold", 12'h0A0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0);

        // Reset in the middle of a conversion.
        send_pair(vecs[3]);
        wait_drain();
        send_byte(8'h19, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        Reset = 1'b0;
        #1;
        check_outputs("abort", 12'h000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("abort_datavalid", 32'(bus.DataValid), 32'd0);
        check("abort_busy",      32'(bus.Busy),      32'd0);
        check("abort_overrun",   32'(bus.Overrun),   32'd0);
        repeat (2) @(posedge clock);
        #1;
        Reset = 1'b1;
        repeat (14) @(posedge clock);
        send_pair(vecs[0]);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
